unit_a_mul_ctrl: RTL and testbench

- Multi-cycle controller that runs 32x32 -> 64-bit shift-and-add multiplies on the shared unit_A arithmetic unit.
- Owns unit_A's A/B/f inputs and consumes its S/c_out outputs; unit_A is instantiated beside it, not inside it.
- Issues one unit_A operation per clock and exposes a start/busy/done handshake to the issuing stage.

---
 rtl/unit_a_mul_ctrl_if.sv | 20 ++
 rtl/unit_a_mul_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_unit_a_mul_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/unit_a_mul_ctrl_if.sv
// rtl/unit_a_mul_ctrl_if.sv - operand/function bus between the multiply controller and unit_A
interface unit_a_mul_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic [3:0]       alu_f;
    logic [WIDTH-1:0] alu_S;
    logic             alu_c_out;

    modport master (
        output alu_A, alu_B, alu_f,
        input  alu_S, alu_c_out
    );

    modport slave (
        input  alu_A, alu_B, alu_f,
        output alu_S, alu_c_out
    );
endinterface

// File: rtl/unit_a_mul_ctrl.sv
// rtl/unit_a_mul_ctrl.sv - shift-and-add 32x32->64 multiply sequencer driving the shared unit_A
// Optional two's-complement operands when UNIT_A_MUL_SIGNED_EN is defined.
module unit_a_mul_ctrl #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    unit_a_mul_ctrl_if.master    alu
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic [3:0] F_ADD = 4'b0100;

`ifdef UNIT_A_MUL_SIGNED_EN
    localparam logic [3:0] F_NOT = 4'b0110;
    localparam logic [3:0] F_INC = 4'b0111;

    typedef enum logic [3:0] {
        S_IDLE, S_RUN, S_DONE,
        S_PRE_A0, S_PRE_A1, S_PRE_B0, S_PRE_B1,
        S_POST_L0, S_POST_L1, S_POST_H0, S_POST_H1
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_RUN, S_DONE
    } state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [WIDTH-1:0] acc_hi, acc_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
`ifdef UNIT_A_MUL_SIGNED_EN
    logic             neg, neg_nxt;
    logic             lo_carry, lo_carry_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc_hi  <= '0;
            cnt     <= '0;
            product <= '0;
`ifdef UNIT_A_MUL_SIGNED_EN
            neg      <= 1'b0;
            lo_carry <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc_hi <= acc_nxt;
            cnt    <= cnt_nxt;
`ifdef UNIT_A_MUL_SIGNED_EN
            neg      <= neg_nxt;
            lo_carry <= lo_carry_nxt;
`endif
            // Latch the value being written this edge so the final step is included
            if (state_nxt == S_DONE)
                product <= {acc_nxt, mplier_nxt};
        end
    end

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc_hi;
        cnt_nxt    = cnt;
        alu.alu_A  = '0;
        alu.alu_B  = '0;
        alu.alu_f  = F_ADD;
        busy       = 1'b0;
        done       = 1'b0;
`ifdef UNIT_A_MUL_SIGNED_EN
        neg_nxt      = neg;
        lo_carry_nxt = lo_carry;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    mcand_nxt  = op_a;
                    mplier_nxt = op_b;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
`ifdef UNIT_A_MUL_SIGNED_EN
                    neg_nxt    = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    state_nxt  = op_a[WIDTH-1] ? S_PRE_A0 :
                                 op_b[WIDTH-1] ? S_PRE_B0 : S_RUN;
`else
                    state_nxt  = S_RUN;
`endif
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                alu.alu_A = acc_hi;
                alu.alu_B = mplier[0] ? mcand : '0;
                // Carry becomes the new top bit, so nothing is lost on max operands
                {acc_nxt, mplier_nxt} = {alu.alu_c_out, alu.alu_S, mplier[WIDTH-1:1]};
                cnt_nxt   = cnt + CW'(1);
                if (cnt == LAST) begin
`ifdef UNIT_A_MUL_SIGNED_EN
                    state_nxt = neg ? S_POST_L0 : S_DONE;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
`ifdef UNIT_A_MUL_SIGNED_EN
            S_PRE_A0: begin
                busy      = 1'b1;
                alu.alu_A = mcand;
                alu.alu_f = F_NOT;
                mcand_nxt = alu.alu_S;
                state_nxt = S_PRE_A1;
            end
            S_PRE_A1: begin
                busy      = 1'b1;
                alu.alu_A = mcand;
                alu.alu_f = F_INC;
                mcand_nxt = alu.alu_S;
                state_nxt = mplier[WIDTH-1] ? S_PRE_B0 : S_RUN;
            end
            S_PRE_B0: begin
                busy       = 1'b1;
                alu.alu_A  = mplier;
                alu.alu_f  = F_NOT;
                mplier_nxt = alu.alu_S;
                state_nxt  = S_PRE_B1;
            end
            S_PRE_B1: begin
                busy       = 1'b1;
                alu.alu_A  = mplier;
                alu.alu_f  = F_INC;
                mplier_nxt = alu.alu_S;
                state_nxt  = S_RUN;
            end
            S_POST_L0: begin
                busy       = 1'b1;
                alu.alu_A  = mplier;
                alu.alu_f  = F_NOT;
                mplier_nxt = alu.alu_S;
                state_nxt  = S_POST_L1;
            end
            S_POST_L1: begin
                busy         = 1'b1;
                alu.alu_A    = mplier;
                alu.alu_f    = F_INC;
                mplier_nxt   = alu.alu_S;
                lo_carry_nxt = alu.alu_c_out;
                state_nxt    = S_POST_H0;
            end
            S_POST_H0: begin
                busy      = 1'b1;
                alu.alu_A = acc_hi;
                alu.alu_f = F_NOT;
                acc_nxt   = alu.alu_S;
                state_nxt = lo_carry ? S_POST_H1 : S_DONE;
            end
            S_POST_H1: begin
                busy      = 1'b1;
                alu.alu_A = acc_hi;
                alu.alu_f = F_INC;
                acc_nxt   = alu.alu_S;
                state_nxt = S_DONE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_unit_a_mul_ctrl.sv
// tb/tb_unit_a_mul_ctrl.sv - scoreboard bench for unit_a_mul_ctrl with a behavioural unit_A beside it
module tb_unit_a_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    unit_a_mul_ctrl_if alu_bus ();

    unit_a_mul_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .alu     (alu_bus)
    );

    always #5 clk = ~clk;

    // unit_A functions used by the controller
    always_comb begin
        alu_bus.alu_S     = '0;
        alu_bus.alu_c_out = 1'b0;
        case (alu_bus.alu_f)
            4'b0100: {alu_bus.alu_c_out, alu_bus.alu_S} = {1'b0, alu_bus.alu_A} + {1'b0, alu_bus.alu_B};
            4'b0101: alu_bus.alu_S = alu_bus.alu_A - alu_bus.alu_B;
            4'b0110: alu_bus.alu_S = ~alu_bus.alu_A;
            4'b0111: {alu_bus.alu_c_out, alu_bus.alu_S} = {1'b0, alu_bus.alu_A} + 33'd1;
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;

    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        logic [63:0] prod;
        int          edge_no;
        int          lat;
    } sb_t;
    sb_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            sb_t e;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("product", product, e.prod);
                chk("latency", 64'(edges - e.edge_no), 64'(e.lat));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    function automatic logic [63:0] exp_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef UNIT_A_MUL_SIGNED_EN
        logic signed [63:0] sa, sbv;
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        return 64'(sa * sbv);
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    // Run one multiply; hold keeps start asserted (with other operands) for that many cycles after acceptance
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [3:0]  fq[$];
        logic [63:0] prev;
        bit          seen;
`ifdef UNIT_A_MUL_SIGNED_EN
        logic [31:0] ma, mb;
        logic [63:0] mp;
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        mp = {32'd0, ma} * {32'd0, mb};
        if (a[31]) begin fq.push_back(4'b0110); fq.push_back(4'b0111); end
        if (b[31]) begin fq.push_back(4'b0110); fq.push_back(4'b0111); end
`endif
        repeat (32) fq.push_back(4'b0100);
`ifdef UNIT_A_MUL_SIGNED_EN
        if (a[31] ^ b[31]) begin
            fq.push_back(4'b0110); fq.push_back(4'b0111); fq.push_back(4'b0110);
            if (mp[31:0] == 32'd0) fq.push_back(4'b0111);
        end
`endif
        prev  = product;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{exp_mul(a, b), edges, fq.size()});
        if (hold == 0) start = 1'b0;
        else begin
            op_a = 32'd7;
            op_b = 32'd7;
        end
        seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            if (k + 1 >= hold) start = 1'b0;
            if (done) seen = 1'b1;
            else begin
                chk("busy", 64'(busy), 64'd1);
                chk("product_hold", product, prev);
                if (fq.size() != 0) chk("alu_f", 64'(alu_bus.alu_f), 64'(fq.pop_front()));
            end
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        chk("alu_f_count", 64'(fq.size()), 64'd0);
        // start during the done cycle must be ignored
        start = 1'b1;
        op_a  = 32'hDEAD0001;
        op_b  = 32'd3;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_done",    64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_alu_A",   64'(alu_bus.alu_A), 64'd0);
        chk("rst_alu_B",   64'(alu_bus.alu_B), 64'd0);
        chk("rst_alu_f",   64'(alu_bus.alu_f), 64'(4'b0100));

        run_op(32'd6, 32'd6, 0);
        chk("lit_6x6", product, 64'h0000_0000_0000_0024);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`ifndef UNIT_A_MUL_SIGNED_EN
        chk("lit_max", product, 64'hFFFF_FFFE_0000_0001);
`endif
        run_op(32'd0, 32'h1234_5678, 20);
        chk("lit_zero", product, 64'd0);
        run_op(32'd7, 32'd7, 0);
        chk("lit_7x7", product, 64'h31);
        run_op(32'h8000_0001, 32'h0001_0003, 0);

        // reset in cycle 15 of a 6*6 run
        op_a  = 32'd6;
        op_b  = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",    64'(busy), 64'd0);
        chk("abort_done",    64'(done), 64'd0);
        chk("abort_product", product, 64'd0);
        chk("abort_alu_f",   64'(alu_bus.alu_f), 64'(4'b0100));
        chk("abort_alu_A",   64'(alu_bus.alu_A), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run_op(32'd3, 32'd5, 0);
        chk("lit_3x5", product, 64'hF);

`ifdef UNIT_A_MUL_SIGNED_EN
        run_op(32'hFFFF_FFFA, 32'd6, 0);
        chk("lit_neg6x6", product, 64'hFFFF_FFFF_FFFF_FFDC);
        run_op(32'h8000_0000, 32'h8000_0000, 0);
        chk("lit_min_sq", product, 64'h4000_0000_0000_0000);
        run_op(32'd0, 32'hFFFF_FFFF, 0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
